// File: rtl/ram_load_pkg.sv
// ram_load_pkg: shared state encoding and default widths for the RAM load arbiter.
// Optional checksum accumulator is enabled with RAM_LOAD_CHECKSUM_EN.
package ram_load_pkg;
  localparam int LD_ADDR_W = 13;
  localparam int LD_DATA_W = 32;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_HOLD = 2'd1,
    LD_LOAD = 2'd2,
    LD_DONE = 2'd3
  } ld_state_e;
endpackage

// File: rtl/ram_load_arbiter_if.sv
// ram_load_arbiter_if: CPU, host loader and RAM port bundle.
// slave = arbiter side, master = CPU/host/RAM side.
interface ram_load_arbiter_if #(
  parameter int ADDR_W = ram_load_pkg::LD_ADDR_W,
  parameter int DATA_W = ram_load_pkg::LD_DATA_W
);
  logic [ADDR_W-1:0] i_cpu_addr;
  logic [DATA_W-1:0] i_cpu_wdata;
  logic              i_cpu_wen;
  logic [DATA_W-1:0] o_cpu_rdata;
  logic              o_cpu_hold;
  logic              i_ld_start;
  logic [ADDR_W-1:0] i_ld_base;
  logic [ADDR_W:0]   i_ld_len;
  logic              i_ld_valid;
  logic [DATA_W-1:0] i_ld_data;
  logic              o_ld_ready;
  logic              o_ld_busy;
  logic              o_ld_done;
  logic [ADDR_W-1:0] o_ram_addr;
  logic [DATA_W-1:0] o_ram_wdata;
  logic              o_ram_wen;
  logic [DATA_W-1:0] i_ram_rdata;

  modport slave (
    input  i_cpu_addr, i_cpu_wdata, i_cpu_wen,
    output o_cpu_rdata, o_cpu_hold,
    input  i_ld_start, i_ld_base, i_ld_len,
    input  i_ld_valid, i_ld_data,
    output o_ld_ready, o_ld_busy, o_ld_done,
    output o_ram_addr, o_ram_wdata, o_ram_wen,
    input  i_ram_rdata
  );

  modport master (
    output i_cpu_addr, i_cpu_wdata, i_cpu_wen,
    input  o_cpu_rdata, o_cpu_hold,
    output i_ld_start, i_ld_base, i_ld_len,
    output i_ld_valid, i_ld_data,
    input  o_ld_ready, o_ld_busy, o_ld_done,
    input  o_ram_addr, o_ram_wdata, o_ram_wen,
    output i_ram_rdata
  );
endinterface

// File: rtl/ram_load_ctr.sv
// ram_load_ctr: load address and remaining-word counter pair.
// Address wraps modulo 2^ADDR_W; remaining count is ADDR_W+1 bits.
module ram_load_ctr #(
  parameter int ADDR_W = ram_load_pkg::LD_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W:0]   i_len,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_rem_zero,
  output logic              o_rem_one
);
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_rem;

  // latch base/length on start, step once per accepted word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr <= '0;
      r_rem  <= '0;
    end else if (i_load) begin
      r_addr <= i_base;
      r_rem  <= i_len;
    end else if (i_inc) begin
      r_addr <= r_addr + 1'b1;
      r_rem  <= r_rem - 1'b1;
    end
  end

  assign o_addr     = r_addr;
  assign o_rem_zero = (r_rem == '0);
  assign o_rem_one  = (r_rem == (ADDR_W+1)'(1));
endmodule

// File: rtl/ram_load_arbiter.sv
// ram_load_arbiter: shares the data-RAM port between the CPU and a host loader.
// Define RAM_LOAD_CHECKSUM_EN to add the o_ld_checksum accumulator output.
module ram_load_arbiter
  import ram_load_pkg::*;
#(
  parameter int ADDR_W      = LD_ADDR_W,
  parameter int DATA_W      = LD_DATA_W,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  ram_load_arbiter_if.slave     bus
`ifdef RAM_LOAD_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]     o_ld_checksum
`endif
);
  localparam logic [3:0] HC_INIT = 4'(HOLD_CYCLES - 1);

  ld_state_e         r_state;
  ld_state_e         w_next;
  logic [3:0]        r_hold_cnt;
  logic              w_start;
  logic              w_hs;
  logic [ADDR_W-1:0] w_addr;
  logic              w_rem_zero;
  logic              w_rem_one;

  assign w_start = (r_state == LD_IDLE) && bus.i_ld_start;
  assign w_hs    = (r_state == LD_LOAD) && bus.i_ld_valid;

  ram_load_ctr #(.ADDR_W(ADDR_W)) u_ctr (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_start),
    .i_base     (bus.i_ld_base),
    .i_len      (bus.i_ld_len),
    .i_inc      (w_hs),
    .o_addr     (w_addr),
    .o_rem_zero (w_rem_zero),
    .o_rem_one  (w_rem_one)
  );

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= LD_IDLE;
    else        r_state <= w_next;
  end

  // drain-interval counter, armed on start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_hold_cnt <= '0;
    else if (w_start)
      r_hold_cnt <= HC_INIT;
    else if (r_state == LD_HOLD && r_hold_cnt != '0)
      r_hold_cnt <= r_hold_cnt - 1'b1;
  end

  // next state and RAM port mux
  always_comb begin
    w_next          = r_state;
    bus.o_cpu_hold  = 1'b0;
    bus.o_ld_busy   = 1'b0;
    bus.o_ld_ready  = 1'b0;
    bus.o_ld_done   = 1'b0;
    bus.o_ram_addr  = bus.i_cpu_addr;
    bus.o_ram_wdata = bus.i_cpu_wdata;
    bus.o_ram_wen   = bus.i_cpu_wen;
    unique case (r_state)
      LD_IDLE: begin
        if (bus.i_ld_start) w_next = LD_HOLD;
      end
      LD_HOLD: begin
        bus.o_cpu_hold = 1'b1;
        bus.o_ld_busy  = 1'b1;
        bus.o_ram_wen  = 1'b0;
        if (r_hold_cnt == '0)
          w_next = w_rem_zero ? LD_DONE : LD_LOAD;
      end
      LD_LOAD: begin
        bus.o_cpu_hold  = 1'b1;
        bus.o_ld_busy   = 1'b1;
        bus.o_ld_ready  = 1'b1;
        bus.o_ram_addr  = w_addr;
        bus.o_ram_wdata = bus.i_ld_data;
        bus.o_ram_wen   = bus.i_ld_valid;
        if (w_hs && w_rem_one) w_next = LD_DONE;
      end
      LD_DONE: begin
        bus.o_cpu_hold = 1'b1;
        bus.o_ld_busy  = 1'b1;
        bus.o_ld_done  = 1'b1;
        bus.o_ram_wen  = 1'b0;
        w_next         = LD_IDLE;
      end
    endcase
  end

  assign bus.o_cpu_rdata = bus.i_ram_rdata;

`ifdef RAM_LOAD_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;

  // running sum of accepted load words
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_csum <= '0;
    else if (w_start) r_csum <= '0;
    else if (w_hs)    r_csum <= r_csum + bus.i_ld_data;
  end

  assign o_ld_checksum = r_csum;
`endif
endmodule
